// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-wide payload register: async reset, synchronous clear, load enable.
module pipe_data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority over load so a flush always empties the register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Registered valid/ready pipeline stage with a 2-entry skid buffer.
// in_ready and out_valid come straight from the state flop, so chained
// stages have no combinational ready path.
// Optional stall counter: define PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_skid_stage: WIDTH and CNT_W must be >= 1");
    end

    skid_state_e      state_q, state_d;
    logic             in_fire, out_fire;
    logic             m_en, s_en;
    logic [WIDTH-1:0] m_d, s_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Main register reloads from the skid entry when draining ST_TWO,
    // otherwise from the upstream payload.
    assign m_d = (state_q == ST_TWO) ? s_q : in_data;

    // State register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Next state and register load enables; illegal encodings fall to ST_EMPTY.
    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        s_en    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    m_en    = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    m_en = 1'b1;
                end else if (in_fire) begin
                    s_en    = 1'b1;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    m_en    = 1'b1;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (clr) state_d = ST_EMPTY;
    end

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (clr),
        .en    (m_en),
        .d     (m_d),
        .q     (out_data)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .CLK   (CLK),
        .RST_n (RST_n),
        .clr   (clr),
        .en    (s_en),
        .d     (in_data),
        .q     (s_q)
    );

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating count of stalled output cycles; flush leaves it alone.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed + random-handshake bench for pipe_skid_stage.
module tb_pipe_skid_stage;

    localparam int W  = 32;
    localparam int CW = 4;

    logic         CLK = 1'b0;
    logic         RST_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic test_reset;
        RST_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_ovalid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_iready: got %b want 1", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_odata: got %h want 0", out_data); end
        @(negedge CLK) RST_n = 1'b1;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        // fill to ST_TWO, then reset asynchronously mid-cycle
        in_valid = 1'b1; in_data = 32'hA1;
        @(negedge CLK) in_data = 32'hA2;
        @(negedge CLK) in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0 || out_data !== 32'hA1) begin n_err++; $display("FAIL rst_fill: got r=%b d=%h want r=0 d=a1", in_ready, out_data); end
        #2 RST_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin n_err++; $display("FAIL rst_mid: got v=%b r=%b d=%h want v=0 r=1 d=0", out_valid, in_ready, out_data); end
`ifdef PIPE_SKID_STALL_CNT_EN
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
`endif
        @(negedge CLK) RST_n = 1'b1;
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                    n_err++; $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
                end
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_rdy_%0d: got %b want 1", i, in_ready); end
            if (i < 16) begin in_valid = 1'b1; in_data = W'(i + 1); end
            else        in_valid = 1'b0;
        end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_one: got v=%b d=%h r=%b want 1/a/1", out_valid, out_data, in_ready); end
        in_data = 32'hB;
        @(negedge CLK);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_two: got v=%b d=%h r=%b want 1/a/0", out_valid, out_data, in_ready); end
        @(negedge CLK);
        n_cmp++; if (out_data !== 32'hA || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold: got d=%h r=%b want a/0", out_data, in_ready); end
        out_ready = 1'b1;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rel: got v=%b d=%h r=%b want 1/b/1", out_valid, out_data, in_ready); end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'hB) begin n_err++; $display("FAIL bp_empty: got v=%b d=%h want 0/b", out_valid, out_data); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        @(negedge CLK) in_data = 32'h22;
        @(negedge CLK);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_two: got r=%b want 0", in_ready); end
        clr = 1'b1; in_data = 32'hC;
        @(negedge CLK);
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin n_err++; $display("FAIL fl_clr: got v=%b r=%b d=%h want 0/1/0", out_valid, in_ready, out_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_quiet_%0d: got %b want 0", i, out_valid); end
        end
        // flush in ST_ONE with both handshakes firing
        in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b0;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin n_err++; $display("FAIL fl_one: got v=%b d=%h want 1/33", out_valid, out_data); end
        clr = 1'b1; in_data = 32'h44; out_ready = 1'b1;
        @(negedge CLK);
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_err++; $display("FAIL fl_one_clr: got v=%b d=%h want 0/0", out_valid, out_data); end
    endtask

    task automatic test_stall_cnt;
`ifdef PIPE_SKID_STALL_CNT_EN
        @(negedge CLK) RST_n = 1'b0;
        #1 RST_n = 1'b1;
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL cnt_rst: got %0d want 0", stall_cnt); end
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
        @(negedge CLK) in_valid = 1'b0;
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL cnt_0: got %0d want 0", stall_cnt); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (stall_cnt !== 4'd3) begin n_err++; $display("FAIL cnt_3: got %0d want 3", stall_cnt); end
        repeat (17) @(negedge CLK);
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_sat: got %0d want 15", stall_cnt); end
        @(negedge CLK);
        n_cmp++; if (stall_cnt !== 4'd15 || out_data !== 32'h55) begin n_err++; $display("FAIL cnt_hold: got %0d d=%h want 15/55", stall_cnt, out_data); end
        clr = 1'b1;
        @(negedge CLK) clr = 1'b0;
        n_cmp++; if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin n_err++; $display("FAIL cnt_clr: got %0d v=%b want 15/0", stall_cnt, out_valid); end
        @(negedge CLK);
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL cnt_idle: got %0d want 15", stall_cnt); end
`endif
    endtask

    task automatic test_random;
        logic [W-1:0] q[$];
        logic [W-1:0] hold_d = '0;
        logic [W-1:0] exp_d;
        logic         stalled = 1'b0;
        logic         ov, ir;
        for (int cyc = 0; cyc < 3004; cyc++) begin
            @(negedge CLK);
            ov = out_valid; ir = in_ready;
            if (stalled) begin
                n_cmp++;
                if (ov !== 1'b1 || out_data !== hold_d) begin n_err++; $display("FAIL rnd_stable_%0d: got v=%b d=%h want 1/%h", cyc, ov, out_data, hold_d); end
            end
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                in_data   = $urandom;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            if (ov && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_dup_%0d: got %h want no beat", cyc, out_data);
                end else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin n_err++; $display("FAIL rnd_data_%0d: got %h want %h", cyc, out_data, exp_d); end
                end
            end
            if (in_valid && ir) q.push_back(in_data);
            stalled = ov && !out_ready;
            hold_d  = out_data;
        end
        @(negedge CLK);
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_end: got left=%0d v=%b want 0/0", q.size(), out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_cnt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
